// File: rtl/ula_pkg.sv
// Shared op/shift encodings and FSM state type for the sequential ULA.
package ula_pkg;

  localparam logic [2:0] OP_A   = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_DEC = 3'b110;
  localparam logic [2:0] OP_B   = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/ula_core.sv
// Combinational ALU stage: WIDTH+1-bit arithmetic so the top bit is carry/borrow.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_A: y = a;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      // The wrapped top bit of a WIDTH+1 subtraction is exactly the unsigned borrow.
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_INC: begin
        sum = {1'b0, a} + ONE;
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = !a[WIDTH-1] && y[WIDTH-1];
      end
      OP_DEC: begin
        sum = {1'b0, a} - ONE;
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = a[WIDTH-1] && !y[WIDTH-1];
      end
      OP_B: y = b;
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential ULA: one-cycle ALU, iterative one-bit-per-cycle shifter, and
// a result accumulator that can be fed back as operand A.
module ula_seq
  import ula_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic [2:0]       op,
  input  logic [1:0]       shop,
  input  logic [SHW-1:0]   shamt,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] acc
);

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_e           state;
  state_e           state_nxt;
  logic [SHW-1:0]   cnt;
  logic [1:0]       shop_q;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  assign alu_a = use_acc ? acc : a;

  ula_core #(.WIDTH(WIDTH)) u_core (
    .a  (alu_a),
    .b  (b),
    .op (op),
    .y  (alu_y),
    .c  (alu_c),
    .v  (alu_v)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  // Z is qualified by DONE so it reads 0 out of reset and while a shift is in flight.
  assign flag_z    = (state == S_DONE) && (result == '0);
  assign flag_n    = result[WIDTH-1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (in_valid) begin
          if ((shop != SH_NONE) && (shamt != '0)) state_nxt = S_SHIFT;
          else                                    state_nxt = S_DONE;
        end
      S_SHIFT:
        if (cnt == CNT_ONE) state_nxt = S_DONE;
      S_DONE:
        if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      cnt    <= '0;
      shop_q <= SH_NONE;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:
          if (in_valid) begin
            result <= alu_y;
            flag_c <= alu_c;
            flag_v <= alu_v;
            cnt    <= shamt;
            shop_q <= shop;
          end
        // Each step leaves the outgoing bit in C, so the last step's bit survives.
        S_SHIFT: begin
          cnt <= cnt - CNT_ONE;
          case (shop_q)
            SH_LSL: begin
              result <= {result[WIDTH-2:0], 1'b0};
              flag_c <= result[WIDTH-1];
            end
            SH_LSR: begin
              result <= {1'b0, result[WIDTH-1:1]};
              flag_c <= result[0];
            end
            SH_ASR: begin
              result <= {result[WIDTH-1], result[WIDTH-1:1]};
              flag_c <= result[0];
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // A clear in the handshake cycle wins over committing the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                acc <= '0;
    else if (acc_clr)                          acc <= '0;
    else if ((state == S_DONE) && out_ready)   acc <= result;
  end

endmodule
